// File: rtl/fir_pkg.sv
// Shared FIR sequencing definitions: controller state encoding and default
// geometry used by both the sequencer and the band filters.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned FIR_TAPS  = 1021;
    localparam int unsigned FIR_DEPTH = 1024;

endpackage

// File: rtl/circ_ptr.sv
// Modulo-DEPTH circular address counter with synchronous load and increment.
module circ_ptr
    import fir_pkg::*;
#(
    parameter int unsigned DEPTH = FIR_DEPTH,
    parameter int unsigned PTR_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [PTR_W-1:0] i_load_val,
    input  logic             i_inc,
    output logic [PTR_W-1:0] o_ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] r_ptr;

    // Load wins over increment so a restart never skips the window base.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_load) begin
            r_ptr <= i_load_val;
        end else if (i_inc) begin
            r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR sample-queue sequencer: tracks queue fill, and on each new sample once full
// sweeps rd_ptr over the last TAPS samples while strobing the band filters.
module fir_seq_ctrl
    import fir_pkg::*;
#(
    parameter int unsigned TAPS  = FIR_TAPS,
    parameter int unsigned DEPTH = FIR_DEPTH,
    parameter int unsigned PTR_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wrt_smpl,
    output logic             wrt_en,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic             sequencing,
    output logic             filt_vld,
    output logic             full,
    output logic             overrun
);

    localparam int unsigned      CNT_W    = $clog2(TAPS + 1);
    localparam logic [CNT_W-1:0] TAPS_C   = CNT_W'(TAPS);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_fill;
    logic [CNT_W-1:0] r_tap;
    logic             r_pending;
    logic             r_overrun;

    logic [CNT_W-1:0] w_fill_nxt;
    logic [PTR_W-1:0] w_wr_nxt;
    logic [PTR_W-1:0] w_rd_base;
    logic             w_can_start;
    logic             w_start;
    logic             w_queue;

    always_comb begin
        w_fill_nxt = r_fill;
        if (wrt_smpl && (r_fill != TAPS_C)) begin
            w_fill_nxt = r_fill + 1'b1;
        end
    end

    assign w_wr_nxt    = wrt_smpl ? ((wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1) : wr_ptr;
    // DEPTH is a power of two, so natural PTR_W wrap gives the modulo.
    assign w_rd_base   = w_wr_nxt - PTR_W'(TAPS);
    assign w_can_start = (r_state == IDLE) || (r_state == DONE);
    assign w_start     = w_can_start && ((wrt_smpl && (w_fill_nxt == TAPS_C)) || r_pending);
    assign w_queue     = wrt_smpl && !w_start && (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_fill    <= '0;
            r_tap     <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_fill <= w_fill_nxt;
            if (w_start) begin
                r_pending <= 1'b0;
            end else if (w_queue) begin
                r_pending <= 1'b1;
                if (r_pending) begin
                    r_overrun <= 1'b1;
                end
            end
            unique case (r_state)
                IDLE, DONE: begin
                    r_tap   <= '0;
                    r_state <= w_start ? SEQ : IDLE;
                end
                SEQ: begin
                    if (r_tap == LAST_TAP) begin
                        r_tap   <= '0;
                        r_state <= DONE;
                    end else begin
                        r_tap <= r_tap + 1'b1;
                    end
                end
                default: begin
                    r_tap   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    circ_ptr #(
        .DEPTH(DEPTH),
        .PTR_W(PTR_W)
    ) u_wr_ptr (
        .clk       (clk),
        .rst       (rst),
        .i_load    (1'b0),
        .i_load_val('0),
        .i_inc     (wrt_smpl),
        .o_ptr     (wr_ptr)
    );

    circ_ptr #(
        .DEPTH(DEPTH),
        .PTR_W(PTR_W)
    ) u_rd_ptr (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_start),
        .i_load_val(w_rd_base),
        .i_inc     (r_state == SEQ),
        .o_ptr     (rd_ptr)
    );

    assign wrt_en     = wrt_smpl;
    assign sequencing = (r_state == SEQ);
    assign filt_vld   = (r_state == DONE);
    assign full       = (r_fill == TAPS_C);
    assign overrun    = r_overrun;

endmodule

// File: doc/fir_seq_ctrl.md
FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 Parameter TAPS, 1021, number of filter taps = sequencing window length in clocks.
REQ-002 Parameter DEPTH, 1024, sample-queue depth (power of 2, DEPTH > TAPS).
REQ-003 Parameter PTR_W, 10, pointer width = log2(DEPTH).
REQ-004 clk  in  1  system clock, all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 wrt_smpl  in  1  one-cycle pulse: new sample presented to queue.
REQ-007 wrt_en  out  1  queue RAM write enable (combinational copy of wrt_smpl).
REQ-008 wr_ptr  out  PTR_W  queue address for next write (registered).
REQ-009 rd_ptr  out  PTR_W  queue read address during sequencing (registered).
REQ-010 sequencing  out  1  window strobe to FIR band filters, high exactly TAPS consecutive clocks per run.
REQ-011 filt_vld  out  1  one-cycle pulse: filter outputs valid.
REQ-012 full  out  1  queue holds at least TAPS samples since reset.
REQ-013 overrun  out  1  sticky: a sample arrived while one start was already pending.

Function
REQ-014 States SHALL be IDLE, SEQ, DONE; sequencing = (state == SEQ); filt_vld = (state == DONE).
REQ-015 On wrt_smpl, wr_ptr SHALL increment by 1 modulo DEPTH at the same edge, in every state.
REQ-016 A fill counter SHALL increment per wrt_smpl and saturate at TAPS; full = (fill == TAPS).
REQ-017 Start condition: (wrt_smpl with post-increment fill == TAPS) or pending set, evaluated in IDLE or DONE.
REQ-018 On start, rd_ptr SHALL load (wr_ptr_next - TAPS) mod DEPTH, where wr_ptr_next is wr_ptr after that edge; state goes to SEQ; pending clears.
REQ-019 In SEQ, rd_ptr SHALL increment modulo DEPTH each clock; a tap counter counts 0..TAPS-1; at TAPS-1 state goes to DONE.
REQ-020 DONE SHALL last exactly one clock; next state SEQ if start condition holds, else IDLE.
REQ-021 Latency: sequencing rises 1 clock after the starting wrt_smpl; filt_vld rises TAPS+1 clocks after it.
REQ-022 wrt_smpl in SEQ (or in DONE without start) SHALL set pending; if pending already set, overrun SHALL set and remain set until reset.
REQ-023 wrt_smpl with fill < TAPS after increment SHALL only write; no start, no pending.
REQ-024 wr_ptr and rd_ptr wrap DEPTH-1 -> 0 with no gap or stall.

Reset
REQ-025 While rst high at an edge: state IDLE, wr_ptr 0, rd_ptr 0, fill 0, tap counter 0, pending 0, overrun 0.
REQ-026 Reset outputs: sequencing 0, filt_vld 0, full 0, overrun 0, wr_ptr 0, rd_ptr 0; wrt_en follows wrt_smpl.
REQ-027 Reset mid-SEQ SHALL drop sequencing the next clock, no filt_vld; refill of TAPS samples required before next run.

Structure
REQ-028 Package fir_pkg SHALL hold the state_t enum (IDLE, SEQ, DONE) and the default TAPS/DEPTH constants shared with the band filters.
REQ-029 One sub-module, circ_ptr (PTR_W-bit modulo-DEPTH counter with load and increment), SHALL be instantiated for wr_ptr and rd_ptr.

Verification (TAPS=4, DEPTH=8 unless stated)
REQ-030 3 wrt_smpl pulses after reset -> wr_ptr 3, full 0, sequencing never high.
REQ-031 4th pulse at edge N -> rd_ptr 0, sequencing high N+1..N+4, rd_ptr 0,1,2,3, filt_vld high N+5 only.
REQ-032 Pulses until wr_ptr wraps (9th sample, wr_ptr_next=1) -> rd_ptr loads 5, then 5,6,7,0 in SEQ.
REQ-033 One pulse during SEQ -> pending; DONE goes directly to SEQ, rd_ptr = wr_ptr - 4; overrun stays 0.
REQ-034 Two pulses during one SEQ -> overrun 1, held through later runs until rst.
REQ-035 rst asserted in 2nd SEQ cycle -> all outputs at reset values next clock; no filt_vld; defaults TAPS=1021 run: sequencing high 1021 clocks.
